memoria_arbitro: RTL
====================

Name: memoria_arbitro

Overview:
Two-port arbiter and clear sequencer in front of the single-port data memory (memoria_dados: 8-bit position, data_in, mw, combinational data_out). Requester 0 is the CPU load/store path and requester 1 is the loader/debug port. Conflicts are resolved round-robin. A hardware clear walks every address writing zero, one word per cycle, so the memory's own bulk-clear input is no longer needed.

Parameters:
ADDR_W, 8, address width of memory and requester ports
DATA_W, 8, data width
DEPTH, 256, number of words cleared (addresses 0..DEPTH-1); DEPTH <= 2**ADDR_W

Ports:
clk  in  1  system clock, all state on rising edge
r_n  in  1  asynchronous active-low reset
req0  in  1  requester 0 access request (level, held until gnt0)
we0  in  1  requester 0 write enable (1 = write, 0 = read)
addr0  in  ADDR_W  requester 0 address
wdata0  in  DATA_W  requester 0 write data
gnt0  out  1  requester 0 access performed this cycle
rdata0  out  DATA_W  requester 0 read data, valid when gnt0 && !we0
req1, we1, addr1, wdata1, gnt1, rdata1: same as port 0, for requester 1
clr_start  in  1  single-cycle pulse: start memory clear
clr_busy  out  1  clear in progress
clr_done  out  1  one-cycle pulse after the last clear write
mem_position  out  ADDR_W  to memory position
mem_data_in  out  DATA_W  to memory data_in
mem_mw  out  1  to memory mw
mem_data_out  in  DATA_W  from memory data_out

Behaviour:
- Reset (r_n low, async): state IDLE, clr_cnt=0, prio pointer=0 (port 0 favoured), clr_done=0. With no req, gnt0=gnt1=0 and mem_mw=0.
- States: IDLE (serve requests), CLEAR (sequencer owns memory).
- IDLE grant logic is combinational and single-cycle:
  - Only one req -> that port granted.
  - Both req -> port named by pointer granted; other gnt=0 and it must hold req.
  - Granted port drives mem_position=addrX, mem_data_in=wdataX, mem_mw=weX. The write lands on the same rising edge; read data = mem_data_out in the same cycle.
  - rdata0/rdata1 are both wired to mem_data_out; valid only per the gnt/we rule.
  - Pointer: on any grant, pointer <= the non-granted port, so uncontested grants also rotate. Worst-case wait is 1 cycle.
- No grant: mem_mw=0; mem_position/mem_data_in = port 0 values (don't-care).
- IDLE and clr_start=1: that cycle is still arbitrated normally; next state CLEAR, clr_cnt<=0.
- CLEAR:
  - gnt0=gnt1=0; clr_busy=1; mem_position=clr_cnt; mem_data_in=0; mem_mw=1; clr_cnt increments each cycle.
  - When clr_cnt==DEPTH-1: last write this cycle, next state IDLE, clr_done=1 for the following cycle (registered).
  - Total clear duration = DEPTH cycles (256 by default).
- clr_start during CLEAR is ignored (no restart).
- clr_busy is a decode of state==CLEAR, so it is 0 in the clr_done cycle. Requests may be granted in the clr_done cycle.
- Reset mid-clear: immediate abort to IDLE; memory is partially cleared (no recovery, by design); no clr_done.
- Pointer is unchanged during CLEAR.

Optional Feature:
MEMORIA_ARB_CONT_EN
- Defined: adds output cont_cnt [7:0], a saturating count of cycles where req0 && req1 in IDLE (i.e., a request was stalled). It saturates at 255, resets to 0 on r_n, and clears when clr_start is accepted.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package memoria_pkg: state enum (ST_IDLE, ST_CLEAR), port index constants PORT_CPU=0 and PORT_AUX=1, default ADDR_W/DATA_W/DEPTH.
- One natural sub-module: memoria_rr2, a 2-way round-robin grant with pointer register (req[1:0] in, gnt[1:0] and pointer out, update enable input). The clear FSM and muxing stay in the top.

Test Plan:
1. Reset, req0=1 we0=1 addr0=0x10 wdata0=0xA5 -> gnt0=1 same cycle, mem_mw=1 mem_position=0x10; next cycle req0 read 0x10 -> rdata0=0xA5 with gnt0=1.
2. Both requests held 4 cycles (pointer=0 after reset) -> grants 0,1,0,1; each requester waits at most 1 cycle.
3. Fill addresses 0x00..0xFF with 0xFF, pulse clr_start -> clr_busy=1 for exactly 256 cycles; mem_position counts 0x00..0xFF with mem_data_in=0; clr_done=1 the cycle after; reads of 0x00, 0x7F, 0xFF return 0x00.
4. req1 held during CLEAR -> gnt1=0 throughout; gnt1=1 in the clr_done cycle; clr_start pulsed at clr_cnt=0x40 has no effect (still 256 cycles total).
5. Assert r_n=0 asynchronously at clr_cnt=0x80 -> clr_busy drops without a clock edge; clr_done never pulses; address 0x90 keeps its pre-clear value.
6. With MEMORIA_ARB_CONT_EN, 5 contended cycles -> cont_cnt=5; 300 contended cycles -> cont_cnt=255; clr_start -> cont_cnt=0.

Source files
------------

// File: rtl/memoria_pkg.sv
// memoria_pkg: shared types and defaults for the memoria_arbitro block.
// FSM state encoding, requester index constants and default geometry.
package memoria_pkg;

  // Arbiter/sequencer states: serve requesters, or sequencer owns memory
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Requester indices inside the 2-bit request/grant vectors
  localparam int PORT_CPU = 0;  // CPU load/store path
  localparam int PORT_AUX = 1;  // loader / debug port

  // Default memory geometry
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;

endpackage

// File: rtl/memoria_arbitro_if.sv
// memoria_arbitro_if: requester, clear-control and memory-side signals of
// the memory arbiter, bundled with modports.
//
// Handshake: reqX is a level request held (with weX/addrX/wdataX stable)
// until the cycle in which gntX is high; gntX=1 means the access happens in
// that very cycle (write lands on the closing rising edge, rdataX is valid
// in that cycle when weX=0). A request not granted must stay asserted.
interface memoria_arbitro_if
  import memoria_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  // requester 0 (CPU)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic [DATA_W-1:0] rdata0;
  // requester 1 (loader/debug)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic [DATA_W-1:0] rdata1;
  // clear sequencer control
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  // single-port memory side
  logic [ADDR_W-1:0] mem_position;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_mw;
  logic [DATA_W-1:0] mem_data_out;

  // arbiter side
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  clr_start, mem_data_out,
    output gnt0, rdata0, gnt1, rdata1,
    output clr_busy, clr_done,
    output mem_position, mem_data_in, mem_mw
  );

  // requesters + memory side (environment)
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output clr_start, mem_data_out,
    input  gnt0, rdata0, gnt1, rdata1,
    input  clr_busy, clr_done,
    input  mem_position, mem_data_in, mem_mw
  );

endinterface

// File: rtl/memoria_rr2.sv
// memoria_rr2: 2-way round-robin grant. Grant is combinational from req and
// the pointer; the pointer names the favoured port and moves to the port
// that was not granted whenever a grant is issued while enabled.
module memoria_rr2
  import memoria_pkg::*;
(
  input  logic       clk,
  input  logic       r_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       ptr
);

  // Single-cycle grant: lone requester wins, contention resolved by pointer
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt[PORT_CPU] = (ptr == 1'b0);
        gnt[PORT_AUX] = (ptr == 1'b1);
      end else begin
        gnt = req;
      end
    end
  end

  // Pointer rotates on every grant, contended or not; frozen while disabled
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      ptr <= 1'b0;
    end else if (en && (gnt != 2'b00)) begin
      // granting port 0 favours port 1 next, and vice versa
      ptr <= gnt[PORT_CPU];
    end
  end

endmodule

// File: rtl/memoria_arbitro.sv
// memoria_arbitro: two-port round-robin arbiter plus hardware clear
// sequencer in front of the single-port data memory (memoria_dados).
// The clear walks addresses 0..DEPTH-1 writing zero, one word per cycle.
// Optional build macro: MEMORIA_ARB_CONT_EN adds cont_cnt, a saturating
// count of contended (both requesting) IDLE cycles.
module memoria_arbitro
  import memoria_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
)
(
  input  logic               clk,
  input  logic               r_n,
  memoria_arbitro_if.slave   bus,
  output state_t             dbg_state,
  output logic               dbg_ptr
`ifdef MEMORIA_ARB_CONT_EN
  ,
  output logic [7:0]         cont_cnt
`endif
);

  // last address written by the clear walk
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              clr_done_q;
  logic              idle;
  logic [1:0]        req_vec;
  logic [1:0]        gnt_vec;
  logic              ptr;

  assign idle               = (state == ST_IDLE);
  assign req_vec[PORT_CPU]  = bus.req0;
  assign req_vec[PORT_AUX]  = bus.req1;

  // Arbitration only runs in IDLE; the clear owns the memory otherwise
  memoria_rr2 u_rr2 (
    .clk (clk),
    .r_n (r_n),
    .req (req_vec),
    .en  (idle),
    .gnt (gnt_vec),
    .ptr (ptr)
  );

  // Clear sequencer FSM: IDLE <-> CLEAR, address counter and done pulse
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_done_q <= 1'b0;
          // the start cycle itself is still arbitrated normally
          if (bus.clr_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          // clr_start is ignored here: no restart of a running clear
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) begin
            state      <= ST_IDLE;
            clr_done_q <= 1'b1;
          end else begin
            clr_done_q <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory-side mux: clear walk, granted port, or inert port-0 defaults
  always_comb begin
    bus.mem_position = bus.addr0;
    bus.mem_data_in  = bus.wdata0;
    bus.mem_mw       = 1'b0;
    if (state == ST_CLEAR) begin
      bus.mem_position = clr_cnt;
      bus.mem_data_in  = '0;
      bus.mem_mw       = 1'b1;
    end else if (gnt_vec[PORT_AUX]) begin
      bus.mem_position = bus.addr1;
      bus.mem_data_in  = bus.wdata1;
      bus.mem_mw       = bus.we1;
    end else if (gnt_vec[PORT_CPU]) begin
      bus.mem_mw       = bus.we0;
    end
  end

  assign bus.gnt0     = gnt_vec[PORT_CPU];
  assign bus.gnt1     = gnt_vec[PORT_AUX];
  // both read ports see the memory output; meaningful only when granted
  assign bus.rdata0   = bus.mem_data_out;
  assign bus.rdata1   = bus.mem_data_out;
  assign bus.clr_busy = (state == ST_CLEAR);
  assign bus.clr_done = clr_done_q;

  assign dbg_state    = state;
  assign dbg_ptr      = ptr;

`ifdef MEMORIA_ARB_CONT_EN
  // Saturating contention counter; accepted clr_start clears it
  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      cont_cnt <= 8'd0;
    end else if (idle && bus.clr_start) begin
      cont_cnt <= 8'd0;
    end else if (idle && bus.req0 && bus.req1 && (cont_cnt != 8'hFF)) begin
      cont_cnt <= cont_cnt + 8'd1;
    end
  end
`endif

endmodule
